rffe_ctrl: RTL and testbench

RFFE_CTRL -- requirements
Module: rffe_ctrl

---
 rtl/rffe_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rffe_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rffe_ctrl.sv
// RF front-end switch controller: register file plus break-before-make sequencing
// of the RF switch vector. Define RFFE_BBM_EN to enable the guarded transition;
// without it every target change is applied on the next clock edge.
module rffe_ctrl #(
  parameter int unsigned PMOD_WIDTH   = 8,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic [4:0]            i_ioc,
  input  logic [7:0]            i_data_in,
  output logic [7:0]            o_data_out,
  input  logic                  i_cs,
  input  logic                  i_fetch_cmd,
  input  logic                  i_load_cmd,
  input  logic                  i_button,
  input  logic [3:0]            i_config,
  output logic [1:0]            o_led,
  output logic [PMOD_WIDTH-1:0] o_pmod,
  output logic [PMOD_WIDTH-1:0] o_pmod_dir,
  output logic [7:0]            o_rf_pins,
  output logic                  o_busy
);

  localparam logic [7:0] Safe    = 8'h56;
  localparam logic [7:0] Version = 8'h02;

  logic [1:0]            dbg_q;
  logic [2:0]            rf_mode_q;
  logic [1:0]            led_q;
  logic [PMOD_WIDTH-1:0] pmod_dir_q;
  logic [PMOD_WIDTH-1:0] pmod_val_q;
  logic [7:0]            rf_pin_q;
  logic [7:0]            data_out_q;
  logic [7:0]            rd_data;
  logic [7:0]            target;
  logic [7:0]            pins_q, pins_d;
  logic [7:0]            count_q, count_d;
  logic                  busy;
  logic                  dbg_act;
  logic                  rd_en, wr_en;

  // Fetch wins over a simultaneous load.
  assign rd_en   = i_cs & i_fetch_cmd;
  assign wr_en   = i_cs & i_load_cmd & ~i_fetch_cmd;
  assign dbg_act = (dbg_q == 2'b01);

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data = 8'h00;
    case (i_ioc)
      5'h00:   rd_data = Version;
      5'h01:   rd_data = {3'b000, rf_mode_q, dbg_q};
      5'h02:   rd_data = {i_button, i_config, 1'b0, led_q};
      5'h03:   rd_data = 8'(pmod_dir_q);
      5'h04:   rd_data = 8'(pmod_val_q);
      5'h05:   rd_data = rf_pin_q;
      5'h06:   rd_data = {6'b000000, dbg_act, busy};
      5'h07:   rd_data = count_q;
      default: rd_data = 8'h00;
    endcase
  end

  // Register file writes and registered read data.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      dbg_q      <= 2'b00;
      rf_mode_q  <= 3'd0;
      led_q      <= 2'b00;
      pmod_dir_q <= '0;
      pmod_val_q <= '0;
      rf_pin_q   <= Safe;
      data_out_q <= 8'h00;
    end else begin
      if (rd_en) data_out_q <= rd_data;
      if (wr_en) begin
        case (i_ioc)
          5'h01: begin
            dbg_q     <= i_data_in[1:0];
            rf_mode_q <= i_data_in[4:2];
          end
          5'h02:   led_q      <= i_data_in[1:0];
          5'h03:   pmod_dir_q <= i_data_in[PMOD_WIDTH-1:0];
          5'h04:   pmod_val_q <= i_data_in[PMOD_WIDTH-1:0];
          5'h05:   rf_pin_q   <= i_data_in;
          default: ;
        endcase
      end
    end
  end

  // Requested switch vector; reserved modes fall back to the safe vector.
  always_comb begin
    target = Safe;
    if (dbg_q == 2'b01) begin
      target = rf_pin_q;
    end else if (dbg_q == 2'b00) begin
      case (rf_mode_q)
        3'd0:    target = 8'h56;
        3'd1:    target = 8'h66;
        3'd2:    target = 8'h9D;
        3'd3:    target = 8'h5D;
        3'd4:    target = 8'h6B;
        3'd5:    target = 8'hAB;
        default: target = Safe;
      endcase
    end
  end

`ifdef RFFE_BBM_EN
  typedef enum logic {StStable, StGuard} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tgt_q, tgt_d;
  logic       busy_q, busy_d;

  // Break-before-make sequencing: park on Safe, hold for the guard, then apply.
  always_comb begin
    state_d = state_q;
    pins_d  = pins_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    case (state_q)
      StStable: begin
        if (target != pins_q) begin
          pins_d = Safe;
          if (target != Safe) begin
            cnt_d   = 8'(GUARD_CYCLES - 1);
            tgt_d   = target;
            busy_d  = 1'b1;
            state_d = StGuard;
          end
        end
      end
      StGuard: begin
        if (target == Safe) begin
          // Pins are already Safe, nothing left to wait for.
          busy_d  = 1'b0;
          state_d = StStable;
        end else if (target != tgt_q) begin
          cnt_d = 8'(GUARD_CYCLES - 1);
          tgt_d = target;
        end else if (cnt_q == 8'd0) begin
          pins_d  = target;
          busy_d  = 1'b0;
          state_d = StStable;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  // Guard state registers.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StStable;
      cnt_q   <= 8'd0;
      tgt_q   <= Safe;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  assign pins_d = target;
  assign busy   = 1'b0;
`endif

  // A write to the count register clears it, overriding a same-cycle increment.
  always_comb begin
    count_d = count_q;
    if (wr_en && (i_ioc == 5'h07)) begin
      count_d = 8'h00;
    end else if (pins_d != pins_q) begin
      count_d = count_q + 8'd1;
    end
  end

  // Switch vector and transition count registers.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      pins_q  <= Safe;
      count_q <= 8'h00;
    end else begin
      pins_q  <= pins_d;
      count_q <= count_d;
    end
  end

  assign o_data_out = data_out_q;
  assign o_led      = led_q;
  assign o_pmod     = pmod_val_q;
  assign o_pmod_dir = pmod_dir_q;
  assign o_rf_pins  = pins_q;
  assign o_busy     = busy;

endmodule

// File: tb/tb_rffe_ctrl.sv
// Testbench for rffe_ctrl: directed scenarios followed by random bus traffic,
// checked against a cycle-level reference model with a read-response scoreboard.
module tb_rffe_ctrl;

  localparam int unsigned PW   = 4;
  localparam int unsigned GC   = 16;
  localparam logic [7:0]  SAFE = 8'h56;
`ifdef RFFE_BBM_EN
  localparam bit Bbm = 1'b1;
`else
  localparam bit Bbm = 1'b0;
`endif
  localparam int unsigned LAT   = Bbm ? GC + 1 : 1;
  localparam logic [7:0]  PMASK = 8'((1 << PW) - 1);
  localparam logic [7:0]  MODE_TBL [8] = '{8'h56, 8'h66, 8'h9D, 8'h5D,
                                          8'h6B, 8'hAB, 8'h56, 8'h56};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    ioc = '0;
  logic [7:0]    din = '0;
  logic          cs = 1'b0, fetch = 1'b0, load = 1'b0, button = 1'b0;
  logic [3:0]    cfg = '0;
  logic [7:0]    dout, pins;
  logic [1:0]    led;
  logic [PW-1:0] pmod, pmod_dir;
  logic          busy;

  rffe_ctrl #(.PMOD_WIDTH(PW), .GUARD_CYCLES(GC)) dut (
    .i_sys_clk  (clk),
    .i_reset    (rst),
    .i_ioc      (ioc),
    .i_data_in  (din),
    .o_data_out (dout),
    .i_cs       (cs),
    .i_fetch_cmd(fetch),
    .i_load_cmd (load),
    .i_button   (button),
    .i_config   (cfg),
    .o_led      (led),
    .o_pmod     (pmod),
    .o_pmod_dir (pmod_dir),
    .o_rf_pins  (pins),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [1:0] m_dbg   = 2'b00;
  logic [2:0] m_mode  = 3'd0;
  logic [1:0] m_led   = 2'b00;
  logic [7:0] m_dir   = 8'h00;
  logic [7:0] m_val   = 8'h00;
  logic [7:0] m_rfpin = SAFE;
  logic [7:0] m_cnt   = 8'h00;
  logic [7:0] m_pins  = SAFE;
  logic       m_busy  = 1'b0;
  logic [7:0] m_prevt = SAFE;
  int         m_run   = 1;
  logic [7:0] rd_q [$];
  bit         rd_flag = 1'b0;

  function automatic logic [7:0] target_of(input logic [1:0] d, input logic [2:0] m,
                                           input logic [7:0] rp);
    if (d == 2'b01) return rp;
    if (d != 2'b00) return SAFE;
    return MODE_TBL[m];
  endfunction

  function automatic logic [7:0] read_of(input logic [4:0] a);
    case (a)
      5'h00:   return 8'h02;
      5'h01:   return {3'b000, m_mode, m_dbg};
      5'h02:   return {button, cfg, 1'b0, m_led};
      5'h03:   return m_dir;
      5'h04:   return m_val;
      5'h05:   return m_rfpin;
      5'h06:   return {6'b0, (m_dbg == 2'b01), m_busy};
      5'h07:   return m_cnt;
      default: return 8'h00;
    endcase
  endfunction

  // Model: the switch vector follows the target once that target has been requested
  // for GC+1 consecutive edges while parked on SAFE; SAFE and unchanged targets apply at once.
  always @(posedge clk or posedge rst) begin : model
    logic [7:0] t;
    logic [7:0] np;
    logic       rd, wr;
    if (rst) begin
      m_dbg = 2'b00; m_mode = 3'd0; m_led = 2'b00; m_dir = 8'h00; m_val = 8'h00;
      m_rfpin = SAFE; m_cnt = 8'h00; m_pins = SAFE; m_busy = 1'b0;
      m_prevt = SAFE; m_run = 1; rd_q.delete(); rd_flag = 1'b0;
    end else begin
      rd = cs & fetch;
      wr = cs & load & ~fetch;
      t  = target_of(m_dbg, m_mode, m_rfpin);
      if (rd) rd_q.push_back(read_of(ioc));
      rd_flag = rd;
      if (t == m_prevt) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prevt = t;
      if (!Bbm || t == SAFE || t == m_pins || (m_pins == SAFE && m_run >= GC + 1)) np = t;
      else np = SAFE;
      if (wr && ioc == 5'h07) m_cnt = 8'h00;
      else if (np != m_pins) m_cnt = m_cnt + 8'd1;
      m_busy = Bbm && (t != np);
      m_pins = np;
      if (wr) begin
        case (ioc)
          5'h01: begin m_dbg = din[1:0]; m_mode = din[4:2]; end
          5'h02: m_led = din[1:0];
          5'h03: m_dir = din & PMASK;
          5'h04: m_val = din & PMASK;
          5'h05: m_rfpin = din;
          default: ;
        endcase
      end
    end
  end

  // Monitor: pops the expected read response when one was issued, otherwise
  // requires o_data_out to hold; checks all other outputs every cycle.
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      held = 8'h00;
    end else if (rd_flag) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_queue: response presented with no expected value at %0t", $time);
      end else begin
        held = rd_q.pop_front();
      end
    end
    check("data_out", dout, held);
    check("rf_pins", pins, m_pins);
    check("busy", busy, m_busy);
    check("led", led, m_led);
    check("pmod", pmod, m_val);
    check("pmod_dir", pmod_dir, m_dir);
  end

  // One bus cycle; entered and left 2 time units after a rising edge.
  task automatic acc(input logic f, input logic l, input logic [4:0] a, input logic [7:0] d);
    cs = 1'b1; fetch = f; load = l; ioc = a; din = d;
    button = 1'($urandom); cfg = 4'($urandom);
    @(posedge clk); #2;
    cs = 1'b0; fetch = 1'b0; load = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      button = 1'($urandom); cfg = 4'($urandom);
      @(posedge clk); #2;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Reset state readback.
    check("reset_pins", pins, SAFE);
    acc(1'b1, 1'b0, 5'h00, 8'h00); check("version", dout, 8'h02);
    acc(1'b1, 1'b0, 5'h01, 8'h00); check("mode_rst", dout, 8'h00);
    acc(1'b1, 1'b0, 5'h06, 8'h00); check("status_rst", dout, 8'h00);

    // Single guarded transition to rx_lpf.
    acc(1'b0, 1'b1, 5'h01, 8'h08);
    cyc(LAT - 1);
    check("guard_safe", pins, SAFE);
    check("guard_busy", busy, Bbm);
    cyc(1);
    check("rx_lpf", pins, 8'h9D);
    check("rx_lpf_busy", busy, 1'b0);
    acc(1'b1, 1'b0, 5'h07, 8'h00); check("count_one", dout, 8'h01);

    // Guard restart on a second target change.
    acc(1'b0, 1'b1, 5'h01, 8'h00);
    cyc(GC + 2);
    acc(1'b0, 1'b1, 5'h01, 8'h08);
    cyc(5);
    acc(1'b0, 1'b1, 5'h01, 8'h14);
    cyc(LAT - 1);
    check("restart_safe", pins, Bbm ? SAFE : 8'h9D);
    cyc(1);
    check("tx_hpf", pins, 8'hAB);

    // Debug vector.
    acc(1'b0, 1'b1, 5'h05, 8'hC3);
    acc(1'b0, 1'b1, 5'h01, 8'h01);
    cyc(GC + 1);
    check("dbg_pins", pins, 8'hC3);
    acc(1'b1, 1'b0, 5'h06, 8'h00); check("status_dbg", dout, 8'h02);

    // Reset in the middle of a guard.
    acc(1'b0, 1'b1, 5'h01, 8'h08);
    cyc(3);
    rst = 1'b1;
    #1;
    check("midguard_rst_pins", pins, SAFE);
    check("midguard_rst_busy", busy, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    acc(1'b1, 1'b0, 5'h06, 8'h00); check("status_after_rst", dout, 8'h00);

    // Narrow PMOD and fetch/load collision.
    acc(1'b0, 1'b1, 5'h04, 8'hFF); check("pmod_ff", pmod, 4'hF);
    acc(1'b1, 1'b0, 5'h04, 8'h00); check("pmod_rb", dout, 8'h0F);
    acc(1'b1, 1'b1, 5'h04, 8'h00); check("collide_rd", dout, 8'h0F);
    check("collide_reg", pmod, 4'hF);

    // Unmapped address and RO version.
    acc(1'b0, 1'b1, 5'h1A, 8'hFF);
    acc(1'b1, 1'b0, 5'h1A, 8'h00); check("unmapped", dout, 8'h00);
    acc(1'b0, 1'b1, 5'h00, 8'hFF);
    acc(1'b1, 1'b0, 5'h00, 8'h00); check("version_ro", dout, 8'h02);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [4:0] a;
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
      if (r < 2) begin
        rst = 1'b1;
        cyc(1 + $urandom_range(0, 1));
        rst = 1'b0;
      end else if (r < 45) begin
        cyc(1 + $urandom_range(0, 3));
      end else if (r < 60) begin
        acc(1'b0, 1'b1, 5'h01, 8'($urandom));
      end else begin
        acc(1'($urandom_range(0, 3) == 0), 1'($urandom), a, 8'($urandom));
      end
    end
    cyc(GC + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
